// File: rtl/srsw_rdata_ram_if.sv
// rtl/srsw_rdata_ram_if.sv - port bundle for the single-read/single-write RAM
interface srsw_rdata_ram_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 32
);
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ren;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output wen, waddr, wdata, ren, raddr,
        input  rdata
    );

    modport slave (
        input  wen, waddr, wdata, ren, raddr,
        output rdata
    );
endinterface

// File: rtl/srsw_rdata_ram.sv
// rtl/srsw_rdata_ram.sv - synchronous 1R1W RAM with registered, read-first read data
module srsw_rdata_ram #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    srsw_rdata_ram_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_comb begin
        mem_d = mem_q;
        if (bus.wen) begin
            mem_d[bus.waddr] = bus.wdata;
        end
    end

    // Read samples mem_q (pre-edge contents), which gives read-first collisions.
    always_comb begin
        rdata_d = rdata_q;
        if (bus.ren) begin
            rdata_d = mem_q[bus.raddr];
        end
    end

    // Storage is deliberately unreset so writes land even while rst_n is low.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_srsw_rdata_ram.sv
// tb/tb_srsw_rdata_ram.sv - directed vector table plus gated-clock random run for srsw_rdata_ram
module tb_srsw_rdata_ram;
    logic clk_raw = 1'b0;
    logic clk_en  = 1'b1;
    logic clk;
    logic rst_n   = 1'b0;

    srsw_rdata_ram_if #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) bus ();

    srsw_rdata_ram #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Gate only changes while clk_raw is low, so the gated clock never glitches.
    always #5 clk_raw = ~clk_raw;
    assign clk = clk_raw & clk_en;

    typedef struct {
        logic        wen;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic        ren;
        logic [1:0]  raddr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem_m [4];
    logic [31:0] exp_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] wa, input logic [31:0] wd,
                         input logic r, input logic [1:0] ra);
        bus.wen   = w;
        bus.waddr = wa;
        bus.wdata = wd;
        bus.ren   = r;
        bus.raddr = ra;
    endtask

    task automatic cycle(input logic gate);
        clk_en = gate;
        @(posedge clk_raw);
        #1;
    endtask

    function automatic vec_t mk(input logic w, input logic [1:0] wa, input logic [31:0] wd,
                                input logic r, input logic [1:0] ra, input logic [31:0] e);
        vec_t v;
        v.wen = w; v.waddr = wa; v.wdata = wd; v.ren = r; v.raddr = ra; v.exp_rdata = e;
        return v;
    endfunction

    initial begin
        drive(1'b0, 2'd0, 32'h0, 1'b0, 2'd0);

        vecs.push_back(mk(1, 2'd2, 32'h12345678, 0, 2'd0, 32'h00000000));
        vecs.push_back(mk(0, 2'd0, 32'h00000000, 1, 2'd2, 32'h12345678));
        vecs.push_back(mk(1, 2'd1, 32'hAAAA5555, 0, 2'd2, 32'h12345678));
        vecs.push_back(mk(1, 2'd0, 32'h11111111, 0, 2'd2, 32'h12345678));
        vecs.push_back(mk(1, 2'd3, 32'h33333333, 0, 2'd2, 32'h12345678));
        vecs.push_back(mk(1, 2'd0, 32'h22222222, 0, 2'd2, 32'h12345678));
        vecs.push_back(mk(1, 2'd3, 32'hCAFEBABE, 0, 2'd2, 32'h12345678));
        vecs.push_back(mk(1, 2'd1, 32'h0F0F0F0F, 1, 2'd1, 32'hAAAA5555));
        vecs.push_back(mk(0, 2'd0, 32'h00000000, 1, 2'd1, 32'h0F0F0F0F));
        vecs.push_back(mk(0, 2'd0, 32'h00000000, 1, 2'd3, 32'hCAFEBABE));
        vecs.push_back(mk(1, 2'd0, 32'h44444444, 1, 2'd0, 32'h22222222));
        vecs.push_back(mk(1, 2'd2, 32'h55555555, 1, 2'd0, 32'h44444444));
        vecs.push_back(mk(0, 2'd0, 32'h00000000, 1, 2'd2, 32'h55555555));

        // Reset state: ren is ignored while rst_n is low.
        @(negedge clk_raw);
        drive(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
        cycle(1'b1);
        chk("reset_state", bus.rdata, 32'h0);
        @(negedge clk_raw);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk_raw);
            drive(vecs[i].wen, vecs[i].waddr, vecs[i].wdata, vecs[i].ren, vecs[i].raddr);
            cycle(1'b1);
            chk($sformatf("vec%0d", i), bus.rdata, vecs[i].exp_rdata);
        end

        // Async reset mid-cycle from a non-zero rdata.
        @(negedge clk_raw);
        drive(1'b1, 2'd1, 32'hDEADBEEF, 1'b0, 2'd0);
        cycle(1'b1);
        @(negedge clk_raw);
        drive(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
        cycle(1'b1);
        chk("preload_deadbeef", bus.rdata, 32'hDEADBEEF);
        #1 rst_n = 1'b0;
        #1 chk("async_reset", bus.rdata, 32'h0);
        @(negedge clk_raw);
        drive(1'b1, 2'd2, 32'h66666666, 1'b1, 2'd1);
        cycle(1'b1);
        chk("reset_hold_ren", bus.rdata, 32'h0);
        @(negedge clk_raw);
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
        cycle(1'b1);
        chk("release_ren0", bus.rdata, 32'h0);
        @(negedge clk_raw);
        drive(1'b0, 2'd0, 32'h0, 1'b1, 2'd3);
        cycle(1'b1);
        chk("reset_keeps_ram", bus.rdata, 32'hCAFEBABE);
        @(negedge clk_raw);
        drive(1'b0, 2'd0, 32'h0, 1'b1, 2'd2);
        cycle(1'b1);
        chk("write_during_reset", bus.rdata, 32'h66666666);

        // Paused clock: inputs toggle, nothing may change.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_raw);
            drive(1'b1, 2'd3, 32'hBAD0BAD0 + k, 1'b1, 2'd1);
            cycle(1'b0);
            chk($sformatf("pause_hold%0d", k), bus.rdata, 32'h66666666);
        end
        @(negedge clk_raw);
        drive(1'b0, 2'd0, 32'h0, 1'b1, 2'd3);
        cycle(1'b1);
        chk("pause_no_write", bus.rdata, 32'hCAFEBABE);

        // Random run against a model that only advances on delivered edges.
        mem_m[0] = 32'h44444444; mem_m[1] = 32'hDEADBEEF;
        mem_m[2] = 32'h66666666; mem_m[3] = 32'hCAFEBABE;
        exp_m    = 32'hCAFEBABE;
        for (int n = 0; n < 400; n++) begin
            logic g;
            @(negedge clk_raw);
            g = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 9) != 0);
            drive(1'($urandom), 2'($urandom), $urandom, 1'($urandom), 2'($urandom));
            #1;
            if (!rst_n) begin
                exp_m = 32'h0;
                chk($sformatf("rnd_async%0d", n), bus.rdata, exp_m);
            end
            cycle(g);
            if (g) begin
                if (rst_n && bus.ren) exp_m = mem_m[bus.raddr];
                if (bus.wen) mem_m[bus.waddr] = bus.wdata;
            end
            chk($sformatf("rnd%0d", n), bus.rdata, exp_m);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
